// File: rtl/flip_sequencer.sv
// Executes one reversi move against the 32x4 board RAM: origin check, 8-direction
// capture scan, read-modify-write flips, then the placed piece.
module flip_sequencer #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       player_black,
    input  logic [3:0] q,
    output logic       wren,
    output logic [4:0] address,
    output logic [3:0] data,
    output logic       busy,
    output logic       done,
    output logic       valid_move,
    output logic [4:0] flip_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_ORG_RD, S_ORG_CHK, S_DIR_INIT, S_SCAN_STEP, S_SCAN_RD, S_SCAN_EVAL,
        S_FLIP_STEP, S_FLIP_RD, S_FLIP_WR, S_DIR_NEXT, S_PLACE_CHK, S_PLACE_RD,
        S_PLACE_WR, S_DONE
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);
    localparam logic [4:0] FLIP_MAX  = 5'd18;

    state_t      r_state, w_next;
    logic [2:0]  r_ox, r_oy, r_cx, r_cy, r_dir, r_run, r_left;
    logic        r_black, r_valid;
    logic [1:0]  r_wait;
    logic [4:0]  r_addr, r_flip;

    logic signed [3:0] w_dx, w_dy, w_nx, w_ny;
    logic        w_off, w_own, w_opp, w_wait_done;
    logic [1:0]  w_cell;
    logic [3:0]  w_wdata;

    always_comb begin
        w_dx = 4'sd0;
        w_dy = 4'sd0;
        case (r_dir)
            3'd0: begin w_dx =  4'sd0; w_dy = -4'sd1; end
            3'd1: begin w_dx =  4'sd1; w_dy = -4'sd1; end
            3'd2: begin w_dx =  4'sd1; w_dy =  4'sd0; end
            3'd3: begin w_dx =  4'sd1; w_dy =  4'sd1; end
            3'd4: begin w_dx =  4'sd0; w_dy =  4'sd1; end
            3'd5: begin w_dx = -4'sd1; w_dy =  4'sd1; end
            3'd6: begin w_dx = -4'sd1; w_dy =  4'sd0; end
            default: begin w_dx = -4'sd1; w_dy = -4'sd1; end
        endcase
    end

    // A step of -1 or 8 in either axis shows up as bit 3 of the signed coordinate.
    assign w_nx        = $signed({1'b0, r_cx}) + w_dx;
    assign w_ny        = $signed({1'b0, r_cy}) + w_dy;
    assign w_off       = w_nx[3] | w_ny[3];
    assign w_cell      = r_cx[0] ? q[3:2] : q[1:0];
    assign w_own       = w_cell[1] & (w_cell[0] == r_black);
    assign w_opp       = w_cell[1] & (w_cell[0] != r_black);
    assign w_wait_done = (r_wait == 2'd0);
    assign w_wdata     = r_cx[0] ? {1'b1, r_black, q[1:0]} : {q[3:2], 1'b1, r_black};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        wren   = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_ORG_RD;
            end
            S_ORG_RD:    if (w_wait_done) w_next = S_ORG_CHK;
            S_ORG_CHK:   w_next = w_cell[1] ? S_DONE : S_DIR_INIT;
            S_DIR_INIT:  w_next = S_SCAN_STEP;
            S_SCAN_STEP: w_next = w_off ? S_DIR_NEXT : S_SCAN_RD;
            S_SCAN_RD:   if (w_wait_done) w_next = S_SCAN_EVAL;
            S_SCAN_EVAL: begin
                if (w_opp)                        w_next = S_SCAN_STEP;
                else if (w_own && r_run != 3'd0)  w_next = S_FLIP_STEP;
                else                              w_next = S_DIR_NEXT;
            end
            S_FLIP_STEP: w_next = S_FLIP_RD;
            S_FLIP_RD:   if (w_wait_done) w_next = S_FLIP_WR;
            S_FLIP_WR: begin
                wren   = 1'b1;
                w_next = (r_left == 3'd1) ? S_DIR_NEXT : S_FLIP_STEP;
            end
            S_DIR_NEXT:  w_next = (r_dir == 3'd7) ? S_PLACE_CHK : S_DIR_INIT;
            S_PLACE_CHK: w_next = (r_flip == 5'd0) ? S_DONE : S_PLACE_RD;
            S_PLACE_RD:  if (w_wait_done) w_next = S_PLACE_WR;
            S_PLACE_WR: begin
                wren   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ox    <= '0;
            r_oy    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_dir   <= '0;
            r_run   <= '0;
            r_left  <= '0;
            r_black <= 1'b0;
            r_valid <= 1'b0;
            r_wait  <= '0;
            r_addr  <= '0;
            r_flip  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_ox    <= x;
                    r_oy    <= y;
                    r_cx    <= x;
                    r_cy    <= y;
                    r_black <= player_black;
                    r_dir   <= 3'd0;
                    r_flip  <= 5'd0;
                    r_valid <= 1'b0;
                    r_addr  <= {y, x[2:1]};
                    r_wait  <= WAIT_INIT;
                end
                S_ORG_RD, S_SCAN_RD, S_FLIP_RD, S_PLACE_RD:
                    if (!w_wait_done) r_wait <= r_wait - 2'd1;
                S_DIR_INIT: begin
                    r_cx  <= r_ox;
                    r_cy  <= r_oy;
                    r_run <= 3'd0;
                end
                S_SCAN_STEP, S_FLIP_STEP: if (!w_off) begin
                    r_cx   <= w_nx[2:0];
                    r_cy   <= w_ny[2:0];
                    r_addr <= {w_ny[2:0], w_nx[2:1]};
                    r_wait <= WAIT_INIT;
                end
                S_SCAN_EVAL: begin
                    if (w_opp) begin
                        r_run <= r_run + 3'd1;
                    end else if (w_own && r_run != 3'd0) begin
                        r_cx   <= r_ox;
                        r_cy   <= r_oy;
                        r_left <= r_run;
                    end
                end
                S_FLIP_WR: begin
                    r_left <= r_left - 3'd1;
                    if (r_flip != FLIP_MAX) r_flip <= r_flip + 5'd1;
                end
                S_DIR_NEXT: r_dir <= r_dir + 3'd1;
                S_PLACE_CHK: if (r_flip != 5'd0) begin
                    r_cx   <= r_ox;
                    r_cy   <= r_oy;
                    r_addr <= {r_oy, r_ox[2:1]};
                    r_wait <= WAIT_INIT;
                end
                S_PLACE_WR: r_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    assign address    = r_addr;
    assign data       = wren ? w_wdata : 4'd0;
    assign valid_move = r_valid;
    assign flip_count = r_flip;

endmodule

// File: tb/tb_flip_sequencer.sv
// Runs directed moves on two sequencers (RD_LAT 1 and 2) in parallel, each with its
// own board RAM, and checks write traces and move results against hand-computed tables.
module tb_flip_sequencer;

    typedef struct packed {
        logic [1:0]       board;
        logic [2:0]       x;
        logic [2:0]       y;
        logic             blk;
        logic [4:0]       flip;
        logic             valid;
        logic [2:0]       nwr;
        logic [31:0]      mask;
        logic [3:0][8:0]  wr;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic [2:0] x = '0, y = '0;
    logic player_black = 1'b0;

    logic [1:0][3:0] q;
    logic [1:0]      wr_en, bz, dn, vm;
    logic [1:0][4:0] addr, fc;
    logic [1:0][3:0] dat;

    logic [3:0] mem1 [32];
    logic [3:0] mem2 [32];
    logic [3:0] img  [32];
    logic [3:0] p2;
    logic       load = 1'b0;
    logic       clr = 1'b0;
    logic [31:0] mask = '1;

    int         n_wr [2];
    int         n_done [2];
    logic       bad [2];
    logic [8:0] wlog [2][8];

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    flip_sequencer #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y),
        .player_black(player_black), .q(q[0]), .wren(wr_en[0]), .address(addr[0]),
        .data(dat[0]), .busy(bz[0]), .done(dn[0]), .valid_move(vm[0]), .flip_count(fc[0])
    );

    flip_sequencer #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y),
        .player_black(player_black), .q(q[1]), .wren(wr_en[1]), .address(addr[1]),
        .data(dat[1]), .busy(bz[1]), .done(dn[1]), .valid_move(vm[1]), .flip_count(fc[1])
    );

    always @(posedge clk) begin
        if (load) mem1 <= img;
        else if (wr_en[0]) mem1[addr[0]] <= dat[0];
        q[0] <= mem1[addr[0]];
    end

    always @(posedge clk) begin
        if (load) mem2 <= img;
        else if (wr_en[1]) mem2[addr[1]] <= dat[1];
        p2   <= mem2[addr[1]];
        q[1] <= p2;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                n_wr[i]   <= 0;
                n_done[i] <= 0;
                bad[i]    <= 1'b0;
            end else begin
                if (wr_en[i]) begin
                    if (n_wr[i] < 8) wlog[i][n_wr[i][2:0]] <= {addr[i], dat[i]};
                    n_wr[i] <= n_wr[i] + 1;
                end
                if (dn[i]) n_done[i] <= n_done[i] + 1;
                if (bz[i] && !mask[addr[i]]) bad[i] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int b, input int xx, input int yy, input int blk,
                                input int flip, input int valid, input int nwr,
                                input logic [31:0] m, input logic [8:0] w0,
                                input logic [8:0] w1, input logic [8:0] w2,
                                input logic [8:0] w3);
        vec_t v;
        v.board = 2'(b);
        v.x     = 3'(xx);
        v.y     = 3'(yy);
        v.blk   = 1'(blk);
        v.flip  = 5'(flip);
        v.valid = 1'(valid);
        v.nwr   = 3'(nwr);
        v.mask  = m;
        v.wr[0] = w0;
        v.wr[1] = w1;
        v.wr[2] = w2;
        v.wr[3] = w3;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Board 0: opening. Board 1: row 0 x=1..7 white. Board 2: E run of 2 and S run of 1 from (2,2).
    task automatic load_board(input int id);
        for (int i = 0; i < 32; i++) img[i] = 4'h0;
        case (id)
            0: begin img[13] = 4'h8; img[14] = 4'h3; img[17] = 4'hC; img[18] = 4'h2; end
            1: begin img[0] = 4'h8; img[1] = 4'hA; img[2] = 4'hA; img[3] = 4'hA; end
            default: begin img[9] = 4'h8; img[10] = 4'hE; img[13] = 4'h2; img[17] = 4'h3; end
        endcase
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s_outs_lat%0d", tag, i + 1),
                int'({wr_en[i], addr[i], dat[i], bz[i], dn[i], vm[i], fc[i]}), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int glitch);
        int cyc;
        load_board(int'(v.board));
        mask = v.mask;
        clr  = 1'b1;
        tick();
        clr          = 1'b0;
        x            = v.x;
        y            = v.y;
        player_black = v.blk;
        start        = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!(n_done[0] > 0 && n_done[1] > 0) && cyc < 2000) begin
            if (cyc == glitch) begin
                start = 1'b1;
                x     = 3'd0;
                y     = 3'd0;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 2000) chk({tag, "_timeout"}, 1, 0);
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_flip_lat%0d", tag, i + 1), int'(fc[i]), int'(v.flip));
            chk($sformatf("%s_valid_lat%0d", tag, i + 1), int'(vm[i]), int'(v.valid));
            chk($sformatf("%s_done_lat%0d", tag, i + 1), n_done[i], 1);
            chk($sformatf("%s_nwr_lat%0d", tag, i + 1), n_wr[i], int'(v.nwr));
            chk($sformatf("%s_addr_lat%0d", tag, i + 1), int'(bad[i]), 0);
            for (int k = 0; k < int'(v.nwr) && k < n_wr[i]; k++)
                chk($sformatf("%s_wr%0d_lat%0d", tag, k, i + 1), int'(wlog[i][k]),
                    int'(v.wr[k]));
        end
    endtask

    initial begin
        vecs[0] = mk(0, 2, 3, 1, 1, 1, 2, '1, {5'd13, 4'hC}, {5'd13, 4'hF}, 9'd0, 9'd0);
        vecs[1] = mk(0, 3, 3, 1, 0, 0, 0, '1, 9'd0, 9'd0, 9'd0, 9'd0);
        vecs[2] = mk(0, 0, 0, 1, 0, 0, 0, '1, 9'd0, 9'd0, 9'd0, 9'd0);
        vecs[3] = mk(1, 0, 0, 1, 0, 0, 0, 32'h0000_001F, 9'd0, 9'd0, 9'd0, 9'd0);
        vecs[4] = mk(2, 2, 2, 1, 3, 1, 4, '1, {5'd9, 4'hC}, {5'd10, 4'hF},
                     {5'd13, 4'h3}, {5'd9, 4'hF});
        vecs[5] = mk(0, 4, 2, 0, 1, 1, 2, '1, {5'd14, 4'h2}, {5'd10, 4'h2}, 9'd0, 9'd0);

        #3;
        check_outputs_zero("reset");
        tick();
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i), -1);

        // A start pulse mid-move with a different origin must not disturb the move.
        run_vec(vecs[4], "start_busy", 6);

        // Abort partway through the scan, then confirm a fresh move runs normally.
        load_board(0);
        x            = 3'd2;
        y            = 3'd3;
        player_black = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) chk($sformatf("pre_abort_busy_lat%0d", i + 1), int'(bz[i]), 1);
        resetn = 1'b0;
        #1;
        check_outputs_zero("abort");
        #3;
        resetn = 1'b1;
        tick();
        run_vec(vecs[0], "after_abort", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/flip_sequencer.md
Name: flip_sequencer

Overview:
- Executes one complete reversi move against the 32x4 board RAM: checks the origin cell, scans all 8 directions for capturable runs, flips captured pieces with read-modify-write, then writes the placed piece.
- Sits between the game FSM (start/done handshake) and the board RAM port.
- Owns wren/address/data while busy; the game FSM must not drive the RAM during that time.

Parameters:
- RD_LAT, 1, cycles between driving address and q being valid for that address (supported values 1 or 2).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to execute a move; sampled only in IDLE.
- x  input  3  column of the move, latched on an accepted start.
- y  input  3  row of the move, latched on an accepted start.
- player_black  input  1  mover colour (1 = black), latched on an accepted start.
- q  input  4  board RAM read data.
- wren  output  1  board RAM write enable.
- address  output  5  board RAM word address.
- data  output  4  board RAM write data.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the move completes.
- valid_move  output  1  result of the last move, valid from the done pulse until the next accepted start.
- flip_count  output  5  pieces flipped by the last move; same validity as valid_move.

Behaviour:
- Cell encoding: 2 bits, bit1 = occupied, bit0 = black.
- pos = 8*y + x; RAM word = pos[5:1]; even pos uses data[1:0], odd pos uses data[3:2].
- Every write is read-modify-write: the partner cell's bits are taken from the q of the same word read immediately before.
- Reset: all outputs 0; state IDLE. Asserting reset mid-move aborts immediately; writes already issued stay in RAM.
- In IDLE, start=1 latches x, y and player_black, clears flip_count and valid_move, and moves to ORG_RD.
- start is ignored while busy.
- ORG_RD: drive the origin address, wren=0, wait RD_LAT cycles.
  - Origin occupied -> DONE with valid_move=0.
  - Origin empty -> DIR_INIT with dir=0.
- Direction order: dir 0..7 = N(dy-1), NE, E(dx+1), SE, S(dy+1), SW, W(dx-1), NW.
- Step coordinates are 4-bit signed; a step outside 0..7 in either axis ends the direction with no read issued.
- SCAN: step outward from the origin, reading each cell (RD_LAT wait) with run=0 at the start of each direction.
  - Opponent cell: run++, continue.
  - Empty cell: end direction, no flips.
  - Off board: end direction, no flips.
  - Own cell with run=0: end direction, no flips.
  - Own cell with run>0: enter FLIP with k=1.
- FLIP: for k=1..run, starting next to the origin and moving outward:
  - read the cell's word (RD_LAT wait);
  - one cycle with wren=1 and that cell's bits set to {1,player_black};
  - flip_count++ per flipped cell.
- After each direction, dir++; after dir 7, go to PLACE.
- PLACE:
  - flip_count=0 -> no write, valid_move=0.
  - flip_count>0 -> read the origin word, write {1,player_black} into the origin cell, valid_move=1.
- DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- wren is high only in write cycles, for exactly one cycle each. When wren=0, address holds the last read address and data is 0.
- flip_count saturates at 18 (maximum legal), so 5 bits never wrap.

Test Plan:
- Reset: assert resetn=0 mid-scan -> all outputs 0 asynchronously, IDLE; after release, start is accepted normally.
- Opening board: white at pos 27 and 36, black at pos 28 and 35. Black plays x=2,y=3 -> write word 13 = 4'b11xx (pos 27 -> black), then word 13 = 4'hF. Result flip_count=1, valid_move=1, one done pulse.
- Occupied origin: move at x=3,y=3 on the opening board -> no wren cycles, valid_move=0, flip_count=0, done pulse.
- No capture: move at x=0,y=0 on the opening board -> 8 directions scanned, zero writes, valid_move=0.
- Edge run: row 0 x=1..7 all white, black plays x=0,y=0 -> E run reaches the edge with no own piece, so no flip and valid_move=0. Also confirm no address is issued for x=8.
- Multi-direction: captures of 2 cells E and 1 cell S -> writes follow the E then S order, then the origin write; flip_count=3. Repeat with RD_LAT=2 and check data is sampled at the correct cycle.
